// File: rtl/fifo_pkg.sv
// fifo_pkg: shared byte width, byte type and address-width helper for the fifo and fifo_arb_ctrl
package fifo_pkg;
  localparam int DW = 8;
  typedef logic [DW-1:0] byte_t;
  function automatic int awidth(input int max_data);
    return $clog2(max_data);
  endfunction
endpackage

// File: rtl/fifo_arb_ctrl_if.sv
// fifo_arb_ctrl_if: producer req_valid/req_data/req_ready, raw fifo wen/wdata/ren/rdata/count, consumer out_valid/out_data/out_ready, full/empty; slave=controller, master=environment
interface fifo_arb_ctrl_if import fifo_pkg::*; #(
  parameter int NREQ = 4,
  parameter int MAX_DATA = 256
);
  localparam int AW = awidth(MAX_DATA);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [DW*NREQ-1:0] req_data;
  logic fifo_wen;
  logic fifo_ren;
  byte_t fifo_wdata;
  byte_t fifo_rdata;
  logic [AW:0] fifo_count;
  logic out_valid;
  logic out_ready;
  byte_t out_data;
  logic full;
  logic empty;
  modport slave (
    input req_valid, req_data, fifo_rdata, fifo_count, out_ready,
    output req_ready, fifo_wen, fifo_wdata, fifo_ren, out_valid, out_data, full, empty
  );
  modport master (
    output req_valid, req_data, fifo_rdata, fifo_count, out_ready,
    input req_ready, fifo_wen, fifo_wdata, fifo_ren, out_valid, out_data, full, empty
  );
endinterface

// File: rtl/fifo_arb_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; req/ptr/en in, one-hot gnt and binary gnt_idx out, first requester at or after ptr wins
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  input  logic                    en,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_idx
);
  localparam int PW = $clog2(NREQ);
  function automatic int slot(input int p, input int k);
    return (p + k) % NREQ;
  endfunction
  logic hit;
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    hit = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (en && !hit && req[slot(int'(ptr), k)]) begin
        hit = 1'b1;
        gnt[slot(int'(ptr), k)] = 1'b1;
        gnt_idx = PW'(slot(int'(ptr), k));
      end
    end
  end
endmodule

// File: rtl/fifo_arb_ctrl.sv
// fifo_arb_ctrl: round-robin write arbiter and 2-entry skid read sequencer for the shared fifo; ports clk, rst_n (async active-low), bus (fifo_arb_ctrl_if.slave)
module fifo_arb_ctrl import fifo_pkg::*; #(
  parameter int NREQ = 4,
  parameter int MAX_DATA = 256
) (
  input logic           clk,
  input logic           rst_n,
  fifo_arb_ctrl_if.slave bus
);
  localparam int AW = awidth(MAX_DATA);
  localparam int PW = $clog2(NREQ);
  localparam logic [AW:0] CNT_MAX = (AW+1)'(MAX_DATA);
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic rd_pend_q, rd_pend_d;
  logic [1:0] skid_occ_q, skid_occ_d, occ_after_pop;
  byte_t skid_q [2];
  byte_t skid_d [2];
  logic [NREQ-1:0] gnt;
  logic [PW-1:0] gnt_idx;
  logic arb_en, wen, ren, pop, push;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req(bus.req_valid),
    .ptr(rr_ptr_q),
    .en(arb_en),
    .gnt(gnt),
    .gnt_idx(gnt_idx)
  );
  always_comb begin
    arb_en = rst_n && bus.fifo_count < CNT_MAX;
    wen = |gnt;
    ren = rst_n && bus.fifo_count != '0 && (skid_occ_q + {1'b0, rd_pend_q}) < 2'd2;
    pop = skid_occ_q != 2'd0 && bus.out_ready;
    push = rd_pend_q;
    occ_after_pop = skid_occ_q - {1'b0, pop};
    rr_ptr_d = wen ? (gnt_idx == PW'(NREQ-1) ? '0 : gnt_idx + 1'b1) : rr_ptr_q;
    rd_pend_d = ren;
    skid_d[0] = push && occ_after_pop == 2'd0 ? bus.fifo_rdata : pop ? skid_q[1] : skid_q[0];
    skid_d[1] = push && occ_after_pop != 2'd0 ? bus.fifo_rdata : skid_q[1];
    skid_occ_d = occ_after_pop + {1'b0, push};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      rd_pend_q <= 1'b0;
      skid_occ_q <= '0;
      skid_q[0] <= '0;
      skid_q[1] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rd_pend_q <= rd_pend_d;
      skid_occ_q <= skid_occ_d;
      skid_q[0] <= skid_d[0];
      skid_q[1] <= skid_d[1];
    end
  end
  assign bus.req_ready = gnt;
  assign bus.fifo_wen = wen;
  assign bus.fifo_wdata = wen ? bus.req_data[int'(gnt_idx)*DW +: DW] : '0;
  assign bus.fifo_ren = ren;
  assign bus.out_valid = skid_occ_q != 2'd0;
  assign bus.out_data = skid_q[0];
  assign bus.full = rst_n && bus.fifo_count == CNT_MAX;
  assign bus.empty = !rst_n || (bus.fifo_count == '0 && !rd_pend_q && skid_occ_q == 2'd0);
endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// tb_fifo_arb_ctrl: directed and random stimulus against a queue-based fifo and scoreboard model
module tb_fifo_arb_ctrl;
  import fifo_pkg::*;
  localparam int NREQ = 4;
  localparam int MAX = 256;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  fifo_arb_ctrl_if #(.NREQ(NREQ), .MAX_DATA(MAX)) bus ();
  fifo_arb_ctrl #(.NREQ(NREQ), .MAX_DATA(MAX)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int failures = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  byte_t fq[$];
  logic [8:0] fcnt = '0;
  byte_t frd = '0;
  logic wen_s = 1'b0;
  logic ren_s = 1'b0;
  byte_t wdata_s = '0;
  assign bus.fifo_count = fcnt;
  assign bus.fifo_rdata = frd;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      fcnt <= '0;
      frd <= '0;
    end else begin
      if (ren_s) begin
        chk("fifo_no_underflow", 32'(fq.size() != 0), 1);
        if (fq.size() != 0) frd <= fq.pop_front();
      end
      if (wen_s) begin
        chk("fifo_no_overflow", 32'(fq.size() < MAX), 1);
        if (fq.size() < MAX) fq.push_back(wdata_s);
      end
      fcnt <= 9'(fq.size());
    end
  end
  byte_t sb[$];
  int exp_ptr = 0;
  int outst = 0;
  int nwr = 0;
  int nrd = 0;
  logic pend_m = 1'b0;
  always @(negedge clk) begin
    logic [NREQ-1:0] eg;
    int gi;
    if (!rst_n) begin
      sb.delete();
      exp_ptr = 0;
      outst = 0;
      pend_m = 1'b0;
      wen_s = 1'b0;
      ren_s = 1'b0;
    end else begin
      eg = '0;
      gi = 0;
      if (fcnt < MAX)
        for (int k = 0; k < NREQ; k++)
          if (eg == '0 && bus.req_valid[(exp_ptr + k) % NREQ]) begin
            gi = (exp_ptr + k) % NREQ;
            eg[gi] = 1'b1;
          end
      chk("req_ready", 32'(bus.req_ready), 32'(eg));
      chk("fifo_wen", 32'(bus.fifo_wen), 32'(eg != '0));
      if (eg != '0) chk("fifo_wdata", 32'(bus.fifo_wdata), 32'(bus.req_data[gi*8 +: 8]));
      chk("fifo_ren", 32'(bus.fifo_ren), 32'(fcnt != 0 && outst < 2));
      chk("out_valid", 32'(bus.out_valid), 32'(outst - int'(pend_m) > 0));
      chk("empty", 32'(bus.empty), 32'(fcnt == 0 && outst == 0));
      chk("full", 32'(bus.full), 32'(fcnt == MAX));
      wen_s = bus.fifo_wen;
      ren_s = bus.fifo_ren;
      wdata_s = bus.fifo_wdata;
      if (bus.out_valid && bus.out_ready) begin
        chk("sb_has_data", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) chk("out_data", 32'(bus.out_data), 32'(sb.pop_front()));
        outst--;
        nrd++;
      end
      if (eg != '0) begin
        sb.push_back(bus.req_data[gi*8 +: 8]);
        exp_ptr = (gi + 1) % NREQ;
        nwr++;
      end
      if (bus.fifo_ren) outst++;
      pend_m = bus.fifo_ren;
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drain(input string tag, input bit tog);
    int t;
    t = 0;
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    while (!bus.empty && t < 3000) begin
      cyc(1);
      if (tog) bus.out_ready = ~bus.out_ready;
      t++;
    end
    chk(tag, 32'(bus.empty), 1);
  endtask
  task automatic mid_reset();
    bus.req_valid = '1;
    bus.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_fifo_wen", 32'(bus.fifo_wen), 0);
    chk("rst_fifo_ren", 32'(bus.fifo_ren), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("post_rst_empty", 32'(bus.empty), 1);
    #1 chk("post_rst_ptr0", 32'(bus.req_ready), 32'h1);
    bus.req_valid = '0;
  endtask
  initial begin
    int bw, br, t;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    mid_reset();
    cyc(1);
    bus.out_ready = 1'b0;
    bus.req_data = 32'hC300_0000;
    bus.req_valid = 4'b1000;
    cyc(1);
    bus.req_valid = '0;
    chk("lat_ren_t1", 32'(bus.fifo_ren), 1);
    chk("lat_ov_t1", 32'(bus.out_valid), 0);
    cyc(1);
    chk("lat_ov_t2", 32'(bus.out_valid), 0);
    cyc(1);
    chk("lat_ov_t3", 32'(bus.out_valid), 1);
    chk("lat_data_t3", 32'(bus.out_data), 32'hC3);
    drain("lat_drain", 1'b0);
    bw = nwr;
    br = nrd;
    bus.req_data = 32'hA3A2_A1A0;
    bus.req_valid = 4'hF;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1 chk("rr_grant", 32'(bus.req_ready), 32'(1 << (k % NREQ)));
      cyc(1);
    end
    cyc(12);
    drain("fair_drain", 1'b0);
    chk("fair_count", 32'(nrd - br), 32'(nwr - bw));
    bw = nwr;
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0001;
    for (int i = 0; i < 300; i++) begin
      bus.req_data[7:0] = 8'(i);
      cyc(1);
    end
    chk("full_flag", 32'(bus.full), 1);
    chk("full_ready", 32'(bus.req_ready), 0);
    chk("full_count", 32'(fcnt), 256);
    chk("full_accepted", 32'(nwr - bw), 258);
    drain("full_drain", 1'b0);
    for (int i = 0; i < 400; i++) begin
      bus.req_valid = 4'($urandom);
      bus.req_data = $urandom;
      bus.out_ready = $urandom_range(0, 3) != 0;
      cyc(1);
    end
    drain("rand_drain", 1'b0);
    br = nrd;
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      bus.req_data = $urandom;
      cyc(1);
    end
    drain("bp_drain", 1'b1);
    chk("bp_count", 32'(nrd - br), 10);
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0001;
    bus.req_data = 32'h11;
    cyc(1);
    bus.req_data = 32'h22;
    cyc(1);
    bus.req_data = 32'h33;
    cyc(1);
    bus.req_valid = '0;
    cyc(5);
    chk("sim_count_pre", 32'(fcnt), 1);
    bus.out_ready = 1'b1;
    cyc(1);
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0010;
    bus.req_data = 32'h4400;
    #1;
    chk("sim_ren", 32'(bus.fifo_ren), 1);
    chk("sim_wen", 32'(bus.fifo_wen), 1);
    chk("sim_count", 32'(fcnt), 1);
    cyc(1);
    bus.req_valid = '0;
    chk("sim_count_post", 32'(fcnt), 1);
    drain("sim_drain", 1'b0);
    bw = nwr;
    br = nrd;
    t = 0;
    bus.out_ready = 1'b1;
    while (nwr - bw < 600 && t < 5000) begin
      bus.req_valid = 4'($urandom_range(1, 15));
      bus.req_data = $urandom;
      cyc(1);
      t++;
    end
    bus.req_valid = '0;
    chk("wrap_written", 32'(nwr - bw), 600);
    drain("wrap_drain", 1'b0);
    chk("wrap_read", 32'(nrd - br), 600);
    for (int i = 0; i < 30; i++) begin
      bus.req_valid = 4'($urandom);
      bus.req_data = $urandom;
      bus.out_ready = $urandom_range(0, 1) != 0;
      cyc(1);
    end
    mid_reset();
    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
